// File: rtl/ex_stage_if.sv
// ID_EX -> EX -> EX/MEM bundle for the execute stage.
// The master side drives the ID_EX fields; the slave side (ex_stage) returns EX/MEM fields and the stall.
interface ex_stage_if #(
  parameter int W = 16
);
  logic [W-1:0] in_PC_plus_two;
  logic [W-1:0] in_Read_data_1;
  logic [W-1:0] in_Read_data_2;
  logic [W-1:0] in_immediate;
  logic         in_ALU_Src;
  logic [1:0]   in_ALUOp;
  logic         in_RegDest;
  logic [2:0]   in_rt;
  logic [2:0]   in_rd;
  logic         in_MemRead;
  logic         in_MemWrite;
  logic         in_Branch;
  logic         in_MemtoReg;
  logic         in_RegWrite;

  logic         ex_stall;
  logic [W-1:0] O_ALU_result;
  logic         O_zero;
  logic [W-1:0] O_write_data;
  logic [2:0]   O_write_register;
  logic [W-1:0] O_branch_target;
  logic         O_PC_Src;
  logic         O_MemRead;
  logic         O_MemWrite;
  logic         O_MemtoReg;
  logic         O_RegWrite;

  modport master (
    output in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate,
           in_ALU_Src, in_ALUOp, in_RegDest, in_rt, in_rd,
           in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite,
    input  ex_stall, O_ALU_result, O_zero, O_write_data, O_write_register,
           O_branch_target, O_PC_Src, O_MemRead, O_MemWrite, O_MemtoReg, O_RegWrite
  );

  modport slave (
    input  in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate,
           in_ALU_Src, in_ALUOp, in_RegDest, in_rt, in_rd,
           in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite,
    output ex_stall, O_ALU_result, O_zero, O_write_data, O_write_register,
           O_branch_target, O_PC_Src, O_MemRead, O_MemWrite, O_MemtoReg, O_RegWrite
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the 16-bit MIPS pipeline: ALU, branch target, destination select,
// iterative shift-add multiplier, and the EX/MEM register (bubbles while mul stalls).
module ex_stage #(
  parameter int W = 16
) (
  input logic         clk,
  input logic         rst_n,
  ex_stage_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state_r;
  logic [3:0]   cnt_r;
  logic [W-1:0] mcand_r;
  logic [W-1:0] mplier_r;
  logic [W-1:0] acc_r;

  logic [W-1:0] op_a_s;
  logic [W-1:0] op_b_s;
  logic [3:0]   funct_s;
  logic         is_mul_s;
  logic         stall_s;
  logic [W-1:0] alu_s;
  logic         zero_s;
  logic [2:0]   wreg_s;
  logic [W-1:0] btgt_s;

  assign op_a_s   = bus.in_Read_data_1;
  assign op_b_s   = bus.in_ALU_Src ? bus.in_immediate : bus.in_Read_data_2;
  assign funct_s  = bus.in_immediate[3:0];
  assign is_mul_s = (bus.in_ALUOp == 2'b10) && (funct_s == 4'd8);
  // DONE is the one mul cycle where the pipeline is released and the product is captured
  assign stall_s  = rst_n && is_mul_s && (state_r != ST_DONE);
  assign bus.ex_stall = stall_s;

  assign zero_s = (alu_s == {W{1'b0}});
  assign wreg_s = bus.in_RegDest ? bus.in_rd : bus.in_rt;
  assign btgt_s = bus.in_PC_plus_two + {bus.in_immediate[W-2:0], 1'b0};

  // ALU result select; mul yields the accumulated product held by the FSM
  always_comb begin
    alu_s = {W{1'b0}};
    case (bus.in_ALUOp)
      2'b00: alu_s = op_a_s + op_b_s;
      2'b01: alu_s = op_a_s - op_b_s;
      2'b11: alu_s = op_a_s | op_b_s;
      2'b10: begin
        case (funct_s)
          4'd0:    alu_s = op_a_s + op_b_s;
          4'd1:    alu_s = op_a_s - op_b_s;
          4'd2:    alu_s = op_a_s & op_b_s;
          4'd3:    alu_s = op_a_s | op_b_s;
          4'd4:    alu_s = {{(W-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
          4'd5:    alu_s = op_a_s << op_b_s[3:0];
          4'd6:    alu_s = op_a_s >> op_b_s[3:0];
          4'd8:    alu_s = acc_r;
          default: alu_s = op_a_s + op_b_s;
        endcase
      end
      default: alu_s = op_a_s + op_b_s;
    endcase
  end

  // Shift-add multiplier: operands latched in IDLE, 16 MUL iterations, one DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      mcand_r  <= {W{1'b0}};
      mplier_r <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            mcand_r  <= op_a_s;
            mplier_r <= op_b_s;
            acc_r    <= {W{1'b0}};
            cnt_r    <= 4'd0;
            state_r  <= ST_MUL;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_MUL;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // EX/MEM register; a stall edge inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (!rst_n || stall_s) begin
      bus.O_ALU_result     <= {W{1'b0}};
      bus.O_zero           <= 1'b0;
      bus.O_write_data     <= {W{1'b0}};
      bus.O_write_register <= 3'd0;
      bus.O_branch_target  <= {W{1'b0}};
      bus.O_PC_Src         <= 1'b0;
      bus.O_MemRead        <= 1'b0;
      bus.O_MemWrite       <= 1'b0;
      bus.O_MemtoReg       <= 1'b0;
      bus.O_RegWrite       <= 1'b0;
    end else begin
      bus.O_ALU_result     <= alu_s;
      bus.O_zero           <= zero_s;
      bus.O_write_data     <= bus.in_Read_data_2;
      bus.O_write_register <= wreg_s;
      bus.O_branch_target  <= btgt_s;
      bus.O_PC_Src         <= bus.in_Branch & zero_s;
      bus.O_MemRead        <= bus.in_MemRead;
      bus.O_MemWrite       <= bus.in_MemWrite;
      bus.O_MemtoReg       <= bus.in_MemtoReg;
      bus.O_RegWrite       <= bus.in_RegWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and popped one per clock when the outputs settle.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_if #(.W(16)) bus ();

  ex_stage #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic [15:0] wd;
    logic [2:0]  wr;
    logic [15:0] bt;
    logic        pcs;
    logic [3:0]  ctl; // {MemRead, MemWrite, MemtoReg, RegWrite}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // ctl = {MemRead, MemWrite, Branch, MemtoReg, RegWrite}
  task automatic set_in(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic alusrc, input logic [1:0] aluop,
                        input logic regdest, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [4:0] ctl);
    bus.in_PC_plus_two = pc;
    bus.in_Read_data_1 = a;
    bus.in_Read_data_2 = b;
    bus.in_immediate   = imm;
    bus.in_ALU_Src     = alusrc;
    bus.in_ALUOp       = aluop;
    bus.in_RegDest     = regdest;
    bus.in_rt          = rt;
    bus.in_rd          = rd;
    bus.in_MemRead     = ctl[4];
    bus.in_MemWrite    = ctl[3];
    bus.in_Branch      = ctl[2];
    bus.in_MemtoReg    = ctl[1];
    bus.in_RegWrite    = ctl[0];
  endtask

  task automatic push_exp(input logic [15:0] res);
    exp_t e;
    e.res  = res;
    e.zero = (res == 16'h0000);
    e.wd   = bus.in_Read_data_2;
    e.wr   = bus.in_RegDest ? bus.in_rd : bus.in_rt;
    e.bt   = bus.in_PC_plus_two + (bus.in_immediate * 16'd2);
    e.pcs  = bus.in_Branch && e.zero;
    e.ctl  = {bus.in_MemRead, bus.in_MemWrite, bus.in_MemtoReg, bus.in_RegWrite};
    exp_q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.res = 16'h0000; e.zero = 1'b0; e.wd = 16'h0000; e.wr = 3'd0;
    e.bt  = 16'h0000; e.pcs  = 1'b0; e.ctl = 4'h0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag, input logic want_stall);
    exp_t e;
    #1;
    chk({tag, ".stall"}, {31'd0, bus.ex_stall}, {31'd0, want_stall});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".res"},  {16'd0, bus.O_ALU_result},     {16'd0, e.res});
      chk({tag, ".zero"}, {31'd0, bus.O_zero},           {31'd0, e.zero});
      chk({tag, ".wd"},   {16'd0, bus.O_write_data},     {16'd0, e.wd});
      chk({tag, ".wr"},   {29'd0, bus.O_write_register}, {29'd0, e.wr});
      chk({tag, ".bt"},   {16'd0, bus.O_branch_target},  {16'd0, e.bt});
      chk({tag, ".pcs"},  {31'd0, bus.O_PC_Src},         {31'd0, e.pcs});
      chk({tag, ".ctl"},  {28'd0, bus.O_MemRead, bus.O_MemWrite, bus.O_MemtoReg, bus.O_RegWrite},
                          {28'd0, e.ctl});
    end
  endtask

  logic [15:0] ra, rb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 5'b00000);
    push_bubble(); tick("rst0", 1'b0);
    // mul at the input while in reset must not stall
    set_in(16'h0, 16'd300, 16'd7, 16'h0008, 1'b0, 2'b10, 1'b1, 3'd1, 3'd5, 5'b00001);
    push_bubble(); tick("rst_mul", 1'b0);
    rst_n = 1'b1;

    set_in(16'h0000, 16'h0005, 16'h0003, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd2, 3'd4, 5'b00001);
    push_exp(16'h0008); tick("add", 1'b0);
    set_in(16'h0010, 16'h1234, 16'h1234, 16'hFFFE, 1'b0, 2'b01, 1'b0, 3'd3, 3'd0, 5'b00100);
    push_exp(16'h0000); tick("beq", 1'b0);
    set_in(16'h0020, 16'hFFFF, 16'h0001, 16'h0004, 1'b0, 2'b10, 1'b1, 3'd0, 3'd1, 5'b00001);
    push_exp(16'h0001); tick("slt_neg", 1'b0);
    set_in(16'h0020, 16'h0001, 16'hFFFF, 16'h0004, 1'b0, 2'b10, 1'b1, 3'd0, 3'd2, 5'b00001);
    push_exp(16'h0000); tick("slt_pos", 1'b0);
    set_in(16'h0022, 16'h0001, 16'h000F, 16'h0005, 1'b0, 2'b10, 1'b1, 3'd0, 3'd3, 5'b00001);
    push_exp(16'h8000); tick("sll", 1'b0);
    set_in(16'h0024, 16'h8000, 16'h0004, 16'h0006, 1'b0, 2'b10, 1'b1, 3'd0, 3'd6, 5'b00001);
    push_exp(16'h0800); tick("srl", 1'b0);
    set_in(16'h0026, 16'hF0F0, 16'h3C3C, 16'h0002, 1'b0, 2'b10, 1'b1, 3'd0, 3'd7, 5'b00011);
    push_exp(16'h3030); tick("and", 1'b0);
    set_in(16'h0028, 16'h00F0, 16'h5555, 16'h000F, 1'b1, 2'b11, 1'b0, 3'd5, 3'd0, 5'b00001);
    push_exp(16'h00FF); tick("ori", 1'b0);
    set_in(16'h002A, 16'h0010, 16'h1111, 16'hFFF0, 1'b1, 2'b00, 1'b0, 3'd2, 3'd0, 5'b10010);
    push_exp(16'h0000); tick("lw_addr", 1'b0);
    set_in(16'h002C, 16'h0005, 16'h0005, 16'h0001, 1'b0, 2'b10, 1'b1, 3'd0, 3'd3, 5'b00100);
    push_exp(16'h0000); tick("sub_br", 1'b0);
    set_in(16'h002E, 16'h0100, 16'h0023, 16'h0007, 1'b0, 2'b10, 1'b1, 3'd0, 3'd4, 5'b00001);
    push_exp(16'h0123); tick("funct7", 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      set_in(16'($urandom), ra, rb, 16'($urandom), 1'b0, (i % 2 == 0) ? 2'b00 : 2'b01,
             1'b0, 3'(i), 3'd0, 5'b01000);
      push_exp((i % 2 == 0) ? 16'((32'(ra) + 32'(rb)) % 32'h10000)
                            : 16'((32'h10000 + 32'(ra) - 32'(rb)) % 32'h10000));
      tick("rand_addsub", 1'b0);
    end

    set_in(16'h0040, 16'd300, 16'd7, 16'h0008, 1'b0, 2'b10, 1'b1, 3'd1, 3'd5, 5'b00001);
    for (int i = 0; i < 17; i++) begin
      push_bubble(); tick("mul300_stall", 1'b1);
    end
    push_exp(16'h0834); tick("mul300_done", 1'b0);

    set_in(16'h0042, 16'h1234, 16'h0100, 16'h0008, 1'b0, 2'b10, 1'b1, 3'd1, 3'd6, 5'b00001);
    for (int i = 0; i < 17; i++) begin
      if (i == 5) bus.in_Read_data_1 = 16'hFFFF;
      push_bubble(); tick("mulwrap_stall", 1'b1);
    end
    bus.in_Read_data_1 = 16'h1234;
    push_exp(16'h3400); tick("mulwrap_done", 1'b0);

    // back-to-back mul restarts from IDLE
    set_in(16'h0044, 16'h0003, 16'h0005, 16'h0008, 1'b0, 2'b10, 1'b1, 3'd1, 3'd2, 5'b00001);
    for (int i = 0; i < 17; i++) begin
      push_bubble(); tick("mulb2b_stall", 1'b1);
    end
    push_exp(16'h000F); tick("mulb2b_done", 1'b0);

    set_in(16'h0046, 16'd300, 16'd7, 16'h0008, 1'b0, 2'b10, 1'b1, 3'd1, 3'd5, 5'b00001);
    for (int i = 0; i < 9; i++) begin
      push_bubble(); tick("mulrst_stall", 1'b1);
    end
    rst_n = 1'b0;
    push_bubble(); tick("mulrst_abort", 1'b0);
    rst_n = 1'b1;
    set_in(16'h0048, 16'h0001, 16'h0002, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd0, 3'd5, 5'b00001);
    push_exp(16'h0003); tick("post_rst_add", 1'b0);
    set_in(16'h004A, 16'h0009, 16'h0004, 16'h0001, 1'b0, 2'b10, 1'b1, 3'd0, 3'd6, 5'b00001);
    push_exp(16'h0005); tick("post_rst_sub", 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
